// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - walks reg_file read ports pairwise and streams {odd,even} beats
// Optional trailing {xor,sum} checksum beat when REG_DUMP_CHECKSUM_EN is defined.
module reg_dump_reader #(
   parameter int NREGS     = 8,
   parameter int ADDR_W    = 3,
   parameter int DATA_W    = 8,
   parameter int READ_WAIT = 1
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_start,
   output logic [ADDR_W-1:0]     o_out1address,
   output logic [ADDR_W-1:0]     o_out2address,
   input  logic [DATA_W-1:0]     i_rddata1,
   input  logic [DATA_W-1:0]     i_rddata2,
   output logic [2*DATA_W-1:0]   o_dout,
   output logic [2:0]            o_beat,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int                NPAIRS    = NREGS / 2;
   localparam logic [ADDR_W-1:0] LAST_K    = ADDR_W'(NPAIRS - 1);
   localparam logic [3:0]        WAIT_INIT = 4'(READ_WAIT);

`ifdef REG_DUMP_CHECKSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_SEND, S_CSUM, S_FIN} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_SEND, S_FIN} state_t;
`endif

   state_t              r_state;
   state_t              w_next;
   logic [ADDR_W-1:0]   r_k;
   logic [ADDR_W-1:0]   r_addr1;
   logic [ADDR_W-1:0]   r_addr2;
   logic [3:0]          r_wait;
   logic [2*DATA_W-1:0] r_dout;
   logic [2:0]          r_beat;
   logic                r_valid;
   logic                w_accept;
   logic                w_last;
   logic                w_capture;

   assign w_accept  = r_valid & i_ready;
   assign w_last    = (r_k == LAST_K);
   assign w_capture = (r_state == S_ADDR) && (r_wait == 4'd0);

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (i_start) w_next = S_ADDR;
         S_ADDR: if (r_wait == 4'd0) w_next = S_SEND;
         S_SEND: begin
            if (w_accept) begin
               if (!w_last) begin
                  w_next = S_ADDR;
               end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                  w_next = S_CSUM;
`else
                  w_next = S_FIN;
`endif
               end
            end
         end
`ifdef REG_DUMP_CHECKSUM_EN
         S_CSUM: if (w_accept) w_next = S_FIN;
`endif
         S_FIN:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

`ifdef REG_DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] r_sum;
   logic [DATA_W-1:0] r_xor;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_sum <= '0;
         r_xor <= '0;
      end else if (r_state == S_IDLE && i_start) begin
         r_sum <= '0;
         r_xor <= '0;
      end else if (w_capture) begin
         r_sum <= r_sum + i_rddata1 + i_rddata2;
         r_xor <= r_xor ^ i_rddata1 ^ i_rddata2;
      end
   end
`endif

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_k     <= '0;
         r_addr1 <= '0;
         r_addr2 <= '0;
         r_wait  <= '0;
         r_dout  <= '0;
         r_beat  <= '0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_k     <= '0;
                  r_addr1 <= '0;
                  r_addr2 <= ADDR_W'(1);
                  r_wait  <= WAIT_INIT;
               end
            end
            S_ADDR: begin
               if (r_wait == 4'd0) begin
                  r_dout  <= {i_rddata2, i_rddata1};
                  r_beat  <= 3'(r_k);
                  r_valid <= 1'b1;
               end else begin
                  r_wait <= r_wait - 4'd1;
               end
            end
            S_SEND: begin
               if (w_accept) begin
                  r_valid <= 1'b0;
                  if (w_last) begin
                     r_addr1 <= '0;
                     r_addr2 <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
                     // checksum beat goes out straight after the last pair
                     r_dout  <= {r_xor, r_sum};
                     r_beat  <= 3'(NPAIRS);
                     r_valid <= 1'b1;
`endif
                  end else begin
                     r_k     <= r_k + ADDR_W'(1);
                     r_addr1 <= r_addr1 + ADDR_W'(2);
                     r_addr2 <= r_addr2 + ADDR_W'(2);
                     r_wait  <= WAIT_INIT;
                  end
               end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            S_CSUM: begin
               if (w_accept) r_valid <= 1'b0;
            end
`endif
            S_FIN: begin
               r_addr1 <= '0;
               r_addr2 <= '0;
            end
            default: ;
         endcase
      end
   end

   assign o_out1address = r_addr1;
   assign o_out2address = r_addr2;
   assign o_dout        = r_dout;
   assign o_beat        = r_beat;
   assign o_valid       = r_valid;
   assign o_busy        = (r_state != S_IDLE);
   assign o_done        = (r_state == S_FIN);

endmodule
